grant_dispatch16: RTL and testbench

Request-side companion to the 16-bit right (lowest-index-wins) arbiter. It latches per-client request pulses into a pending vector that drives the arbiter's `r` input, and samples the one-hot grant `g` that comes back. It encodes the grant to a 4-bit client index, hands the index to a downstream consumer over a valid/ready handshake, and retires the granted request once the consumer accepts it. It also flags illegal grant vectors from the arbiter.

---
 rtl/grant_dispatch16.sv | 135 +++++++++++++
 tb/tb_grant_dispatch16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/grant_dispatch16.sv
// Request-side companion to a 16-client lowest-index-wins arbiter.
// Latches request pulses into the arbiter's r vector and dispatches each grant as an index over valid/ready.
module grant_dispatch16 #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_set,
    output logic [N-1:0]  r,
    input  logic [N-1:0]  g,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    input  logic          out_ready,
    output logic [IW:0]   pending_cnt,
    output logic          ovf,
    output logic          err_grant,
    input  logic          err_clr
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_pend;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_next;
    logic          r_valid;
    logic          w_valid_next;
    logic [IW:0]   r_cnt;
    logic          r_ovf;
    logic          r_err;

    logic          w_accept;
    logic [N-1:0]  w_clr_mask;
    logic [N-1:0]  w_r_next;
    logic          w_dup;
    logic          w_onehot;
    logic          w_legal;
    logic          w_bad_grant;
    logic [IW-1:0] w_enc;
    logic [IW:0]   w_cnt_next;

    // Handshake retirement and pending-vector update; a same-cycle set overrides the clear
    assign w_accept   = (r_state == ST_PRESENT) && out_ready;
    assign w_clr_mask = w_accept ? (N'(1) << r_idx) : '0;
    assign w_r_next   = (r_pend & ~w_clr_mask) | req_set;
    assign w_dup      = |(req_set & r_pend & ~w_clr_mask);

    // A legal grant is exactly one-hot and only grants a pending client
    assign w_onehot   = (g != '0) && ((g & (g - N'(1))) == '0);
    assign w_legal    = w_onehot && ((g & ~r_pend) == '0);

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (g[i]) begin
                w_enc = w_enc | IW'(i);
            end
        end
    end

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_cnt_next = w_cnt_next + (IW+1)'(w_r_next[i]);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_bad_grant  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    if (w_legal) begin
                        w_idx_next   = w_enc;
                        w_state_next = ST_PRESENT;
                    end else begin
                        w_bad_grant  = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_valid_next = (w_state_next == ST_PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_r_next;
            r_idx   <= w_idx_next;
            r_valid <= w_valid_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ovf <= w_dup       | (r_ovf & ~err_clr);
            r_err <= w_bad_grant | (r_err & ~err_clr);
        end
    end

    assign r           = r_pend;
    assign out_valid   = r_valid;
    assign out_idx     = r_idx;
    assign pending_cnt = r_cnt;
    assign ovf         = r_ovf;
    assign err_grant   = r_err;

endmodule

// File: tb/tb_grant_dispatch16.sv
// Directed bench for grant_dispatch16 with a behavioural lowest-index-wins arbiter and a grant override.
module tb_grant_dispatch16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_set;
    logic [15:0] r;
    logic [15:0] g;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic        out_ready;
    logic [4:0]  pending_cnt;
    logic        ovf;
    logic        err_grant;
    logic        err_clr;

    logic        g_ovr_en;
    logic [15:0] g_ovr;

    int n_checks = 0;
    int n_pass   = 0;

    grant_dispatch16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_set     (req_set),
        .r           (r),
        .g           (g),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_ready   (out_ready),
        .pending_cnt (pending_cnt),
        .ovf         (ovf),
        .err_grant   (err_grant),
        .err_clr     (err_clr)
    );

    // Lowest set bit of r wins unless a grant is being forced
    assign g = g_ovr_en ? g_ovr : (r & (~r + 16'd1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] idx,
                             input logic [15:0] rv, input logic [4:0] cnt);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, ".idx"}, 32'(out_idx), 32'(idx));
        check({tag, ".r"}, 32'(r), 32'(rv));
        check({tag, ".cnt"}, 32'(pending_cnt), 32'(cnt));
    endtask

    logic [3:0]  exp_idx [4];
    logic [15:0] exp_r   [4];

    initial begin
        rst_n     = 1'b0;
        req_set   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        g_ovr_en  = 1'b0;
        g_ovr     = '0;
        tick(); tick();
        check_out("reset", 1'b0, 4'd0, 16'h0000, 5'd0);
        check("reset.idx", 32'(out_idx), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        check("reset.err", 32'(err_grant), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request
        req_set = 16'h0020; out_ready = 1'b1;
        tick(); req_set = '0;
        check_out("single.e0", 1'b0, 4'd0, 16'h0020, 5'd1);
        tick();
        check_out("single.e1", 1'b1, 4'd5, 16'h0020, 5'd1);
        tick();
        check_out("single.e2", 1'b0, 4'd0, 16'h0000, 5'd0);

        // Priority and drain
        exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
        exp_r   = '{16'h8420, 16'h8400, 16'h8000, 16'h0000};
        req_set = 16'h8421;
        tick(); req_set = '0;
        check_out("drain.load", 1'b0, 4'd0, 16'h8421, 5'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("drain.present", 1'b1, exp_idx[k], (k == 0) ? 16'h8421 : exp_r[k-1], 5'(4 - k));
            tick();
            check_out("drain.accept", 1'b0, 4'd0, exp_r[k], 5'(3 - k));
        end

        // Backpressure
        out_ready = 1'b0; req_set = 16'h0006;
        tick(); req_set = '0;
        check_out("bp.load", 1'b0, 4'd0, 16'h0006, 5'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("bp.hold", 1'b1, 4'd1, 16'h0006, 5'd2);
        end
        out_ready = 1'b1;
        tick();
        check_out("bp.acc1", 1'b0, 4'd0, 16'h0004, 5'd1);
        tick();
        check_out("bp.idx2", 1'b1, 4'd2, 16'h0004, 5'd1);
        tick();
        check_out("bp.acc2", 1'b0, 4'd0, 16'h0000, 5'd0);
        check("bp.ovf", 32'(ovf), 32'd0);

        // Set/clear collision: set wins and the fresh request is not a duplicate
        out_ready = 1'b0; req_set = 16'h0008;
        tick(); req_set = '0;
        tick();
        check_out("coll.present", 1'b1, 4'd3, 16'h0008, 5'd1);
        out_ready = 1'b1; req_set = 16'h0008;
        tick(); req_set = '0; out_ready = 1'b0;
        check_out("coll.accept", 1'b0, 4'd0, 16'h0008, 5'd1);
        check("coll.ovf", 32'(ovf), 32'd0);
        tick();
        check_out("coll.again", 1'b1, 4'd3, 16'h0008, 5'd1);
        // Duplicate request while still pending
        req_set = 16'h0008;
        tick(); req_set = '0;
        check("dup.ovf", 32'(ovf), 32'd1);
        check_out("dup.hold", 1'b1, 4'd3, 16'h0008, 5'd1);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        check("dup.clr", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        check_out("dup.drain", 1'b0, 4'd0, 16'h0000, 5'd0);

        // Illegal grants
        g_ovr_en = 1'b1; g_ovr = 16'h0003; req_set = 16'h0001;
        tick(); req_set = '0;
        check("ill.noerr_empty", 32'(err_grant), 32'd0);
        tick();
        check("ill.multi.err", 32'(err_grant), 32'd1);
        check("ill.multi.valid", 32'(out_valid), 32'd0);
        err_clr = 1'b1; g_ovr = 16'h0000;
        tick(); err_clr = 1'b0;
        check("ill.zero.err", 32'(err_grant), 32'd1);
        check("ill.zero.valid", 32'(out_valid), 32'd0);
        err_clr = 1'b1; g_ovr = 16'h0002;
        tick(); err_clr = 1'b0;
        check("ill.notpend.err", 32'(err_grant), 32'd1);
        check("ill.notpend.valid", 32'(out_valid), 32'd0);
        g_ovr_en = 1'b0;
        tick();
        check_out("ill.recover", 1'b1, 4'd0, 16'h0001, 5'd1);
        tick();
        check_out("ill.accept", 1'b0, 4'd0, 16'h0000, 5'd0);
        check("ill.sticky", 32'(err_grant), 32'd1);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        check("ill.clr", 32'(err_grant), 32'd0);

        // Async reset mid-dispatch
        out_ready = 1'b0; req_set = 16'hFFFF;
        tick(); req_set = '0;
        check_out("rst.load", 1'b0, 4'd0, 16'hFFFF, 5'd16);
        tick();
        check_out("rst.present", 1'b1, 4'd0, 16'hFFFF, 5'd16);
        req_set = 16'h0001;
        tick(); req_set = '0;
        check("rst.ovf_pre", 32'(ovf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_out("rst.async", 1'b0, 4'd0, 16'h0000, 5'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        check("rst.err", 32'(err_grant), 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("rst.quiet", 1'b0, 4'd0, 16'h0000, 5'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
